// File: rtl/seg7_scan_capture.sv
// Recovers the hex value shown on a scanned, active-low 7-segment bus.
// Digits are accepted after a stable hold and assembled into a word with validity and a change strobe.
module seg7_scan_capture #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg_in,
  input  logic [NUM_DIGITS-1:0]   an_in,
  output logic [4*NUM_DIGITS-1:0] value_out,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    value_strobe,
  output logic                    err_pulse
);

  localparam int PW = NUM_DIGITS + 7;

  typedef enum logic [1:0] {IDLE, COUNT, HELD} state_t;

  state_t                  r_state, w_next;
  logic [7:0]              r_cnt, w_cnt_next, w_run;
  logic [PW-1:0]           r_pair, r_prev;
  logic [4*NUM_DIGITS-1:0] r_value, r_last;
  logic [NUM_DIGITS-1:0]   r_valid;
  logic                    r_once, r_acc_pend, r_strobe, r_err;

  logic                  w_match, w_an_ok, w_accept;
  logic [NUM_DIGITS-1:0] w_an_sel;
  logic [5:0]            w_dec;

  // Returns {legal, blank, nibble}; an illegal pattern has both flags low.
  function automatic logic [5:0] decode(input logic [6:0] s);
    case (s)
      7'b1000000: decode = {2'b10, 4'h0};
      7'b1111001: decode = {2'b10, 4'h1};
      7'b0100100: decode = {2'b10, 4'h2};
      7'b0110000: decode = {2'b10, 4'h3};
      7'b0011001: decode = {2'b10, 4'h4};
      7'b0010010: decode = {2'b10, 4'h5};
      7'b0000010: decode = {2'b10, 4'h6};
      7'b1111000: decode = {2'b10, 4'h7};
      7'b0000000: decode = {2'b10, 4'h8};
      7'b0010000: decode = {2'b10, 4'h9};
      7'b0001000: decode = {2'b10, 4'hA};
      7'b0000011: decode = {2'b10, 4'hB};
      7'b1000110: decode = {2'b10, 4'hC};
      7'b0100001: decode = {2'b10, 4'hD};
      7'b0000110: decode = {2'b10, 4'hE};
      7'b0001110: decode = {2'b10, 4'hF};
      7'b1111111: decode = {2'b01, 4'h0};
      default:    decode = {2'b00, 4'h0};
    endcase
  endfunction

  assign w_an_sel = ~r_pair[PW-1:7];
  assign w_an_ok  = $onehot(w_an_sel);
  assign w_match  = (r_pair == r_prev);
  assign w_dec    = decode(r_pair[6:0]);

  // w_run is the number of identical consecutive samples including the one in r_pair.
  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_cnt;
    w_accept   = 1'b0;
    w_run      = '0;
    if (!w_match || !w_an_ok) begin
      w_next     = IDLE;
      w_cnt_next = '0;
    end else begin
      case (r_state)
        IDLE:    w_run = 8'd2;
        COUNT:   w_run = r_cnt + 8'd1;
        default: w_run = r_cnt;
      endcase
      if (r_state != HELD) begin
        w_cnt_next = w_run;
        if (w_run >= 8'(STABLE_CYCLES)) begin
          w_next   = HELD;
          w_accept = 1'b1;
        end else begin
          w_next = COUNT;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_pair     <= '1;
      r_prev     <= '1;
      r_value    <= '0;
      r_valid    <= '0;
      r_last     <= '0;
      r_once     <= 1'b0;
      r_acc_pend <= 1'b0;
      r_strobe   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_prev     <= r_pair;
      r_pair     <= {an_in, seg_in};
      r_state    <= w_next;
      r_cnt      <= w_cnt_next;
      r_acc_pend <= w_accept;
      r_err      <= 1'b0;
      r_strobe   <= 1'b0;
      if (w_accept) begin
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
          if (w_an_sel[i]) begin
            if (w_dec[5]) begin
              r_value[4*i +: 4] <= w_dec[3:0];
              r_valid[i]        <= 1'b1;
            end else begin
              r_valid[i] <= 1'b0;
            end
          end
        end
        r_err <= ~w_dec[5] & ~w_dec[4];
      end
      // Strobe decision looks at the word one cycle after the acceptance wrote it.
      if (r_acc_pend && (&r_valid) && (!r_once || (r_value != r_last))) begin
        r_strobe <= 1'b1;
        r_last   <= r_value;
        r_once   <= 1'b1;
      end
    end
  end

  assign value_out    = r_value;
  assign digit_valid  = r_valid;
  assign value_strobe = r_strobe;
  assign err_pulse    = r_err;

endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with NUM_DIGITS=4, STABLE_CYCLES=4.
module tb_seg7_scan_capture;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  an_in = 4'hF;
  logic [15:0] value_out;
  logic [3:0]  digit_valid;
  logic        value_strobe;
  logic        err_pulse;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int n_strobe = 0;
  int n_err = 0;
  int strobe_cyc = -1;
  int valid_cyc = -100;
  logic [3:0] prev_valid = 4'h0;

  localparam logic [6:0] G1 = 7'b1111001, G2 = 7'b0100100, G3 = 7'b0110000;
  localparam logic [6:0] G4 = 7'b0011001, GA = 7'b0001000, GF = 7'b0001110;
  localparam logic [6:0] G8 = 7'b0000000, BL = 7'b1111111, BAD = 7'b1010101;

  seg7_scan_capture #(.NUM_DIGITS(4), .STABLE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .seg_in(seg_in), .an_in(an_in),
    .value_out(value_out), .digit_valid(digit_valid),
    .value_strobe(value_strobe), .err_pulse(err_pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input logic [3:0] an, input logic [6:0] seg, input int n);
    an_in  = an;
    seg_in = seg;
    repeat (n) begin
      @(posedge clk);
      #1;
      cyc++;
      if (value_strobe === 1'b1) begin
        n_strobe++;
        strobe_cyc = cyc;
      end
      if (err_pulse === 1'b1) n_err++;
      if (digit_valid === 4'hF && prev_valid !== 4'hF) valid_cyc = cyc;
      prev_valid = digit_valid;
    end
  endtask

  task automatic clr();
    n_strobe = 0;
    n_err    = 0;
  endtask

  task automatic scan(input logic [6:0] d0, input logic [6:0] d1,
                      input logic [6:0] d2, input logic [6:0] d3);
    hold(4'b1110, d0, 6); hold(4'hF, BL, 2);
    hold(4'b1101, d1, 6); hold(4'hF, BL, 2);
    hold(4'b1011, d2, 6); hold(4'hF, BL, 2);
    hold(4'b0111, d3, 6); hold(4'hF, BL, 2);
  endtask

  initial begin
    hold(4'hF, BL, 2);
    chk("rst_value", 32'(value_out), 32'h0);
    chk("rst_valid", 32'(digit_valid), 32'h0);
    chk("rst_strobe", 32'(value_strobe), 32'h0);
    chk("rst_err", 32'(err_pulse), 32'h0);
    rst = 1'b0;

    // stability boundary: 3 cycles rejected, 4 accepted and visible at t+5
    clr();
    hold(4'b1110, GA, 3);
    hold(4'hF, BL, 3);
    chk("short_value", 32'(value_out), 32'h0);
    chk("short_valid", 32'(digit_valid), 32'h0);
    hold(4'b1110, GA, 4);
    chk("t4_value", 32'(value_out), 32'h0);
    hold(4'hF, BL, 1);
    chk("t5_value", 32'(value_out), 32'h000A);
    chk("t5_valid", 32'(digit_valid), 32'h1);
    hold(4'hF, BL, 2);
    chk("partial_no_strobe", 32'(n_strobe), 32'h0);

    rst = 1'b1;
    hold(4'hF, BL, 1);
    rst = 1'b0;
    chk("rst2_value", 32'(value_out), 32'h0);
    chk("rst2_valid", 32'(digit_valid), 32'h0);

    // full scan
    clr();
    scan(G1, G2, G3, G4);
    chk("scan_value", 32'(value_out), 32'h4321);
    chk("scan_valid", 32'(digit_valid), 32'hF);
    chk("scan_strobes", 32'(n_strobe), 32'h1);
    chk("scan_strobe_lat", 32'(strobe_cyc - valid_cyc), 32'h1);
    chk("scan_err", 32'(n_err), 32'h0);

    // illegal glyph on digit 2
    clr();
    hold(4'b1011, BAD, 8);
    hold(4'hF, BL, 3);
    chk("bad_err", 32'(n_err), 32'h1);
    chk("bad_valid", 32'(digit_valid), 32'hB);
    chk("bad_value", 32'(value_out), 32'h4321);
    chk("bad_strobe", 32'(n_strobe), 32'h0);

    // unchanged rescan, then change digit 1
    clr();
    scan(G1, G2, G3, G4);
    chk("rescan_strobe", 32'(n_strobe), 32'h0);
    chk("rescan_value", 32'(value_out), 32'h4321);
    chk("rescan_valid", 32'(digit_valid), 32'hF);
    clr();
    hold(4'b1101, GF, 6);
    hold(4'hF, BL, 3);
    chk("chg_strobe", 32'(n_strobe), 32'h1);
    chk("chg_value", 32'(value_out), 32'h43F1);

    // two anodes low
    clr();
    hold(4'b1100, G8, 10);
    hold(4'hF, BL, 2);
    chk("inv_value", 32'(value_out), 32'h43F1);
    chk("inv_valid", 32'(digit_valid), 32'hF);
    chk("inv_err", 32'(n_err), 32'h0);
    chk("inv_strobe", 32'(n_strobe), 32'h0);

    // reset mid-count
    clr();
    hold(4'b1110, G8, 2);
    rst = 1'b1;
    hold(4'b1110, G8, 1);
    rst = 1'b0;
    chk("mid_rst_value", 32'(value_out), 32'h0);
    chk("mid_rst_valid", 32'(digit_valid), 32'h0);
    chk("mid_rst_strobe", 32'(value_strobe), 32'h0);
    chk("mid_rst_err", 32'(err_pulse), 32'h0);
    hold(4'b1110, G8, 3);
    chk("fresh3_value", 32'(value_out), 32'h0);
    chk("fresh3_valid", 32'(digit_valid), 32'h0);
    hold(4'b1110, G8, 1);
    chk("fresh4_value", 32'(value_out), 32'h0);
    hold(4'b1110, G8, 1);
    chk("fresh_acc_value", 32'(value_out), 32'h0008);
    chk("fresh_acc_valid", 32'(digit_valid), 32'h1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seg7_scan_capture.md
# seg7_scan_capture

Reads a multiplexed, active-low 7-segment display bus (segment lines plus per-digit anode selects) and reconstructs the hexadecimal value being shown. It is the reverse of the hex-to-7-segment path: it is used for on-board loopback and self-check of display drivers, and as a front end for any block that must interpret a scanned display. A digit is accepted only after its pattern has been stable for a programmable number of cycles. Accepted digits are assembled into a multi-digit word with per-digit validity and a change strobe.

## Interface

- `NUM_DIGITS`, default 4: number of multiplexed digits (1–8).
- `STABLE_CYCLES`, default 4: consecutive identical samples required before a digit pattern is accepted (2–255).

- `clk`  in  1  single system clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `seg_in`  in  7  segment lines, active-low, bit 0 = a … bit 6 = g.
- `an_in`  in  NUM_DIGITS  digit selects, active-low; bit i low selects digit i.
- `value_out`  out  4*NUM_DIGITS  assembled value; digit i occupies bits [4i+3:4i].
- `digit_valid`  out  NUM_DIGITS  bit i = 1 when slot i holds a decoded digit.
- `value_strobe`  out  1  one-cycle pulse when a complete, changed value is available.
- `err_pulse`  out  1  one-cycle pulse when an accepted pattern is not a legal glyph.

## Operation

- Legal glyphs are the 16 active-low patterns 0–F: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110. Bit strings are written g..a.
- Blank pattern 1111111 is legal as "digit off".
- Sample pair = {an_in, seg_in}, registered on each edge and compared with the previous registered pair.
- The FSM has three states:
  - IDLE: anode invalid or pair changing. Counter = 0.
  - COUNT: `an_in` has exactly one bit low, and the pair matches the previous sample. Counter increments each matching cycle.
  - HELD: pair accepted. Stays in HELD until the pair changes.
- Transitions:
  - Any pair change goes to IDLE, then COUNT on the next matching sample.
  - An invalid anode (all high, or more than one bit low) goes to IDLE and writes nothing. All-high is normal inter-digit blanking and raises no error.
  - COUNT goes to HELD when the pair has been identical for `STABLE_CYCLES` consecutive samples. Acceptance happens once per stable episode.
- On acceptance for digit i:
  - Legal glyph: write the nibble to slot i and set `digit_valid[i]`.
  - Blank: clear `digit_valid[i]`; the slot nibble is unchanged; no error.
  - Illegal pattern: `err_pulse` = 1, clear `digit_valid[i]`, the slot nibble is unchanged.
- Strobe rule: the block keeps a last-strobed value register and a `strobed_once` flag. `value_strobe` fires when, after an acceptance, all `digit_valid` bits are 1 and either `strobed_once` = 0 or `value_out` ≠ last-strobed value. The last-strobed register is updated at the same time.
- Re-accepting an identical digit produces no strobe.

## Timing

- Reset values:
  - `value_out` = 0, `digit_valid` = 0, `value_strobe` = 0, `err_pulse` = 0.
  - FSM = IDLE, counter = 0, sample register = all-ones (anodes off).
  - Last-strobed value = 0, `strobed_once` = 0.
- Acceptance latency: a pair first present at the ports in cycle t and held through cycle t+STABLE_CYCLES-1 updates `value_out`, `digit_valid` and `err_pulse` visibly in cycle t+STABLE_CYCLES+1.
- `value_strobe` is asserted one cycle after the `value_out` update that causes it.
- A pair held for only `STABLE_CYCLES`-1 cycles is never accepted.
- The counter saturates in HELD; arbitrarily long holds produce a single acceptance.
- `rst` asserted mid-count or in HELD takes effect at the next edge. The partial digit is discarded and all outputs return to their reset values.
- All outputs are registered; there are no combinational input-to-output paths.

## Test plan

- Reset then scan: digits 0..3 show 1,2,3,4 (`an_in` = 1110/1101/1011/0111), each held 6 cycles with 2 blank cycles between. Required: `value_out` = 0x4321, `digit_valid` = 1111, and exactly one `value_strobe`, 1 cycle after digit 3 is accepted.
- Stability boundary: digit 0 = A held 3 cycles, then all anodes off. Required: no update. Same glyph held 4 cycles: `value_out[3:0]` = 0xA, visible in cycle t+5.
- Illegal glyph: seg 1010101 on digit 2 held 8 cycles. Required: one `err_pulse`, `digit_valid[2]` = 0, slot 2 nibble unchanged, no strobe.
- Unchanged rescan: repeat the full 0x4321 scan. Required: no `value_strobe`. Change digit 1 to F: one strobe, `value_out` = 0x43F1.
- Invalid anode: `an_in` = 1100 with a legal glyph held 10 cycles. Required: no writes, no error, FSM stays IDLE.
- Reset mid-count: digit 0 = 8 held 2 cycles, `rst` pulsed for 1 cycle, then held 3 more cycles. Required: all outputs 0 and no acceptance until 4 fresh stable cycles have passed.
